// File: rtl/fxp_mul_pkg.sv
// Shared constants and types for the pipelined fixed-point multiplier.
// Optional feature macro: FXP_MUL_ROUND_EN (round-half-up before the shift).
package fxp_mul_pkg;

    // Default configuration matches the sampler's 63-bit fractional datapath
    localparam int FXP_W      = 63;
    localparam int FXP_FRAC   = 63;
    localparam int FXP_STAGES = 3;

    // Legal parameter ranges, checked at elaboration by the top level
    localparam int W_MIN      = 8;
    localparam int W_MAX      = 64;
    localparam int FRAC_MIN   = 1;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 6;

    // Full-precision product for the default width
    typedef logic [2*FXP_W-1:0] prod_t;

    function automatic bit range_ok(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/fxp_pipe_reg.sv
// One pipeline slot: enable-gated data + valid register.
// Invalid slots load zero so downstream data never carries stale values.
// Optional feature macro: FXP_MUL_ROUND_EN (not used in this file).
module fxp_pipe_reg
    import fxp_mul_pkg::*;
#(
    parameter int DW = FXP_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    output logic [DW-1:0] out_data
);

    logic          vld_q;
    logic          vld_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    // Next state: hold when stalled, otherwise capture (zero-masked when invalid)
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (en) begin
            vld_d  = in_vld;
            data_d = in_vld ? in_data : '0;
        end
    end

    // Slot register with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_data = data_q;

endmodule

// File: rtl/fxp_mul_pipe.sv
// Pipelined unsigned fixed-point multiplier: out_ab = (a*b) >> FRAC, W bits.
// Valid/ready handshake; the whole pipe stalls together when the output is
// held, and empty slots keep filling while the output is not valid.
// Optional feature macro: FXP_MUL_ROUND_EN adds 2^(FRAC-1) before the shift.
module fxp_mul_pipe
    import fxp_mul_pkg::*;
#(
    parameter int W      = FXP_W,
    parameter int FRAC   = FXP_FRAC,
    parameter int STAGES = FXP_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_ab
);

    localparam int LO   = W / 2;      // low half of in_b
    localparam int HI   = W - LO;     // high half of in_b
    localparam int PW   = 2 * W;      // full product width
    localparam int PPW  = 3 * W;      // both partial products side by side
    localparam int DLY0 = (STAGES == 1) ? 1 : 2;  // first pure-delay stage

    // Reject unsupported configurations at elaboration
    if (!range_ok(W, W_MIN, W_MAX)) begin : g_bad_w
        $error("fxp_mul_pipe: W out of range");
    end
    if (!range_ok(FRAC, FRAC_MIN, W)) begin : g_bad_frac
        $error("fxp_mul_pipe: FRAC out of range");
    end
    if (!range_ok(STAGES, STAGES_MIN, STAGES_MAX)) begin : g_bad_stages
        $error("fxp_mul_pipe: STAGES out of range");
    end

    logic              en;
    logic [STAGES-1:0] vld;
    logic [W-1:0]      res_data [STAGES];

    // Final arithmetic stage shared by all depths
    logic [PW-1:0]     prod_fin;
    logic [PW:0]       sum_fin;
    logic [PW:0]       shifted;
    logic [W-1:0]      res_fin;
    logic              unused_hi;

`ifdef FXP_MUL_ROUND_EN
    localparam logic [PW:0] RND_ADD = (PW+1)'(1) << (FRAC - 1);
`endif

    // Whole pipe advances unless a valid result is being held
    assign en        = out_ready || !out_valid;
    assign in_ready  = en;
    assign out_valid = vld[STAGES-1];
    assign out_ab    = res_data[STAGES-1];

    // Optional rounding into a carry-preserving sum, then take P[FRAC +: W]
    always_comb begin
`ifdef FXP_MUL_ROUND_EN
        sum_fin = {1'b0, prod_fin} + RND_ADD;
`else
        sum_fin = {1'b0, prod_fin};
`endif
        shifted = sum_fin >> FRAC;
        res_fin = shifted[W-1:0];
    end

    // Bits above the result window are intentionally dropped (wrap, no saturation)
    assign unused_hi = ^shifted[PW:W];

    genvar gi;

    if (STAGES == 1) begin : g_single
        // Single-stage: full product formed combinationally, registered once
        assign prod_fin = PW'(in_a) * PW'(in_b);

        fxp_pipe_reg #(.DW(W)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .in_vld   (in_valid),
            .in_data  (res_fin),
            .out_vld  (vld[0]),
            .out_data (res_data[0])
        );
    end else begin : g_split
        logic [W+LO-1:0] pp_lo_in;
        logic [W+HI-1:0] pp_hi_in;
        logic [W+LO-1:0] pp_lo_s;
        logic [W+HI-1:0] pp_hi_s;
        logic [PPW-1:0]  pp_stage;

        // Stage 0: two half-width partial products on the halves of in_b
        assign pp_lo_in = (W+LO)'(in_a) * (W+LO)'(in_b[LO-1:0]);
        assign pp_hi_in = (W+HI)'(in_a) * (W+HI)'(in_b[W-1:LO]);

        fxp_pipe_reg #(.DW(PPW)) u_pp (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .in_vld   (in_valid),
            .in_data  ({pp_hi_in, pp_lo_in}),
            .out_vld  (vld[0]),
            .out_data (pp_stage)
        );

        // Stage 1: recombine the partial products into the exact 2W-bit product
        assign {pp_hi_s, pp_lo_s} = pp_stage;
        assign prod_fin    = PW'(pp_lo_s) + (PW'(pp_hi_s) << LO);
        assign res_data[0] = '0;

        fxp_pipe_reg #(.DW(W)) u_sum (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .in_vld   (vld[0]),
            .in_data  (res_fin),
            .out_vld  (vld[1]),
            .out_data (res_data[1])
        );
    end

    // Remaining stages only delay the finished result
    for (gi = DLY0; gi < STAGES; gi++) begin : g_delay
        fxp_pipe_reg #(.DW(W)) u_dly (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .in_vld   (vld[gi-1]),
            .in_data  (res_data[gi-1]),
            .out_vld  (vld[gi]),
            .out_data (res_data[gi])
        );
    end

endmodule
